// File: rtl/timer_pkg.sv
// Shared definitions for the timer preset editor.
//   state_t        : editor FSM states (IDLE, EDIT, LOAD)
//   DIG_*          : cursor index of each editable preset digit
//   DIGIT_MAX      : per-digit maximum value, nibble i = max of digit i
//   NIB_W/PRESET_W : BCD nibble width and full preset width
//   digit_max()    : DIGIT_MAX lookup by cursor index
package timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EDIT = 2'd1,
    ST_LOAD = 2'd2
  } state_t;

  localparam int NIB_W       = 4;
  localparam int PRESET_W    = 36;
  localparam int MS_W        = 12;
  localparam int EDIT_DIGITS = 6;

  localparam logic [2:0] DIG_S1   = 3'd0;
  localparam logic [2:0] DIG_S2   = 3'd1;
  localparam logic [2:0] DIG_M1   = 3'd2;
  localparam logic [2:0] DIG_M2   = 3'd3;
  localparam logic [2:0] DIG_H1   = 3'd4;
  localparam logic [2:0] DIG_H2   = 3'd5;
  localparam logic [2:0] DIG_LAST = DIG_H2;

  // h2 h1 m2 m1 s2 s1
  localparam logic [EDIT_DIGITS*NIB_W-1:0] DIGIT_MAX = {4'd9, 4'd9, 4'd5, 4'd9, 4'd5, 4'd9};

  function automatic logic [NIB_W-1:0] digit_max(input logic [2:0] idx);
    case (idx)
      DIG_S1:  return DIGIT_MAX[3:0];
      DIG_S2:  return DIGIT_MAX[7:4];
      DIG_M1:  return DIGIT_MAX[11:8];
      DIG_M2:  return DIGIT_MAX[15:12];
      DIG_H1:  return DIGIT_MAX[19:16];
      DIG_H2:  return DIGIT_MAX[23:20];
      default: return 4'd9;
    endcase
  endfunction

endpackage

// File: rtl/bcd_digit_step.sv
// Combinational single-digit BCD increment/decrement with wrap.
//   digit   : current nibble value
//   max_val : largest legal value of this digit (5 or 9)
//   inc     : +1, max_val wraps to 0
//   dec     : -1, 0 wraps to max_val (inc wins if both set)
//   result  : stepped value, or digit unchanged when neither is set
module bcd_digit_step
  import timer_pkg::*;
(
  input  logic [NIB_W-1:0] digit,
  input  logic [NIB_W-1:0] max_val,
  input  logic             inc,
  input  logic             dec,
  output logic [NIB_W-1:0] result
);

  always_comb begin
    result = digit;
    if (inc) begin
      result = (digit >= max_val) ? '0 : digit + 4'd1;
    end else if (dec) begin
      result = (digit == '0) ? max_val : digit - 4'd1;
    end
  end

endmodule

// File: rtl/timer_preset_editor.sv
// Button-driven editor for a 36-bit BCD countdown preset.
//   clk_i, resetn      : clock, asynchronous active-low reset
//   btn_c_i            : enter edit / commit (load)
//   btn_u_i, btn_d_i   : step the selected digit up / down
//   btn_l_i, btn_r_i   : move cursor to more / less significant digit
//   run_i              : downstream timer running; aborts and blocks editing
//   preset_o           : BCD preset h2 h1 m2 m1 s2 s1 plus three zero ms digits
//   load_o             : one-cycle strobe while in LOAD
//   edit_o             : high in EDIT
//   cursor_o           : selected digit index, 0 = s1 .. 5 = h2
//   blink_o            : display enable for the selected digit
module timer_preset_editor
  import timer_pkg::*;
#(
  parameter int CLK_HZ   = 100_000_000,
  parameter int BLINK_HZ = 2
) (
  input  logic                clk_i,
  input  logic                resetn,
  input  logic                btn_c_i,
  input  logic                btn_u_i,
  input  logic                btn_d_i,
  input  logic                btn_l_i,
  input  logic                btn_r_i,
  input  logic                run_i,
  output logic [PRESET_W-1:0] preset_o,
  output logic                load_o,
  output logic                edit_o,
  output logic [2:0]          cursor_o,
  output logic                blink_o
);

  localparam int BLINK_PERIOD = CLK_HZ / (2 * BLINK_HZ);
  localparam int CNT_W        = (BLINK_PERIOD > 1) ? $clog2(BLINK_PERIOD) : 1;
  localparam logic [CNT_W-1:0] BLINK_LAST = CNT_W'(BLINK_PERIOD - 1);

  state_t                        state, state_next;
  logic [2:0]                    cursor;
  logic [EDIT_DIGITS*NIB_W-1:0]  digits;
  logic [CNT_W-1:0]              blink_cnt;
  logic                          blink;

  logic                          act_enter, act_u, act_d, act_l, act_r;
  logic [NIB_W-1:0]              sel_digit, step_digit;

  // Next state plus a one-hot action decode; the if/else chain is the
  // button priority, so lower-priority pulses in the same cycle vanish.
  always_comb begin
    state_next = state;
    act_enter  = 1'b0;
    act_u      = 1'b0;
    act_d      = 1'b0;
    act_l      = 1'b0;
    act_r      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (btn_c_i && !run_i) begin
          state_next = ST_EDIT;
          act_enter  = 1'b1;
        end
      end
      ST_EDIT: begin
        if (run_i)        state_next = ST_IDLE;
        else if (btn_c_i) state_next = ST_LOAD;
        else if (btn_u_i) act_u = 1'b1;
        else if (btn_d_i) act_d = 1'b1;
        else if (btn_l_i) act_l = 1'b1;
        else if (btn_r_i) act_r = 1'b1;
      end
      ST_LOAD: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge resetn) begin
    if (!resetn) state <= ST_IDLE;
    else         state <= state_next;
  end

  always_comb begin
    sel_digit = '0;
    for (int i = 0; i < EDIT_DIGITS; i++) begin
      if (cursor == 3'(i)) sel_digit = digits[i*NIB_W +: NIB_W];
    end
  end

  bcd_digit_step u_step (
    .digit   (sel_digit),
    .max_val (digit_max(cursor)),
    .inc     (act_u),
    .dec     (act_d),
    .result  (step_digit)
  );

  always_ff @(posedge clk_i or negedge resetn) begin
    if (!resetn) begin
      digits <= '0;
    end else begin
      for (int i = 0; i < EDIT_DIGITS; i++) begin
        if ((act_u || act_d) && cursor == 3'(i)) digits[i*NIB_W +: NIB_W] <= step_digit;
      end
    end
  end

  always_ff @(posedge clk_i or negedge resetn) begin
    if (!resetn) begin
      cursor <= DIG_S1;
    end else if (act_enter) begin
      cursor <= DIG_S1;
    end else if (act_l) begin
      cursor <= (cursor == DIG_LAST) ? DIG_S1 : cursor + 3'd1;
    end else if (act_r) begin
      cursor <= (cursor == DIG_S1) ? DIG_LAST : cursor - 3'd1;
    end
  end

  // Blink divider: parked at 0 with the digit visible whenever we are not
  // (staying) in EDIT; any edit action restarts the phase so the digit is
  // shown immediately after it changes.
  always_ff @(posedge clk_i or negedge resetn) begin
    if (!resetn) begin
      blink_cnt <= '0;
      blink     <= 1'b1;
    end else if (state_next != ST_EDIT || act_enter) begin
      blink_cnt <= '0;
      blink     <= 1'b1;
    end else if (act_u || act_d || act_l || act_r) begin
      blink_cnt <= '0;
      blink     <= 1'b1;
    end else if (blink_cnt == BLINK_LAST) begin
      blink_cnt <= '0;
      blink     <= ~blink;
    end else begin
      blink_cnt <= blink_cnt + 1'b1;
    end
  end

  // load_o/edit_o decode the state directly so an asynchronous reset
  // during LOAD drops the strobe at once.
  assign load_o   = (state == ST_LOAD);
  assign edit_o   = (state == ST_EDIT);
  assign cursor_o = cursor;
  assign blink_o  = blink;
  assign preset_o = {digits, {MS_W{1'b0}}};

endmodule

// File: tb/tb_timer_preset_editor.sv
module tb_timer_preset_editor;

  logic        clk_i = 1'b0;
  logic        resetn = 1'b0;
  logic        btn_c_i = 1'b0, btn_u_i = 1'b0, btn_d_i = 1'b0;
  logic        btn_l_i = 1'b0, btn_r_i = 1'b0, run_i = 1'b0;
  logic [35:0] preset_o;
  logic        load_o, edit_o, blink_o;
  logic [2:0]  cursor_o;

  int n_vec = 0;
  int n_err = 0;

  timer_preset_editor #(.CLK_HZ(1000), .BLINK_HZ(50)) dut (
    .clk_i    (clk_i),
    .resetn   (resetn),
    .btn_c_i  (btn_c_i),
    .btn_u_i  (btn_u_i),
    .btn_d_i  (btn_d_i),
    .btn_l_i  (btn_l_i),
    .btn_r_i  (btn_r_i),
    .run_i    (run_i),
    .preset_o (preset_o),
    .load_o   (load_o),
    .edit_o   (edit_o),
    .cursor_o (cursor_o),
    .blink_o  (blink_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    bit          rst;
    bit          c, u, d, l, r, run;
    logic [35:0] preset;
    logic        ld, ed;
    logic [2:0]  cur;
    logic        bl;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(bit rst, bit c, bit u, bit d, bit l, bit r, bit run,
                              logic [35:0] p, logic ld, logic ed, logic [2:0] cur, logic bl);
    vec_t v;
    v.rst = rst; v.c = c; v.u = u; v.d = d; v.l = l; v.r = r; v.run = run;
    v.preset = p; v.ld = ld; v.ed = ed; v.cur = cur; v.bl = bl;
    return v;
  endfunction

  task automatic chk(input string name, input logic [35:0] act, input logic [35:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic pulse(input bit c, input bit u, input bit d, input bit l, input bit r, input bit run);
    btn_c_i = c; btn_u_i = u; btn_d_i = d; btn_l_i = l; btn_r_i = r; run_i = run;
    @(posedge clk_i); #1;
    btn_c_i = 0; btn_u_i = 0; btn_d_i = 0; btn_l_i = 0; btn_r_i = 0; run_i = 0;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    @(posedge clk_i); #1;
    resetn = 1'b1;
  endtask

  task automatic idle_cycle();
    @(posedge clk_i); #1;
  endtask

  initial begin
    //           rst c u d l r run  preset              ld ed cur bl
    tbl.push_back(mk(1,0,0,0,0,0,0, 36'h0_0000_0000, 0, 0, 0, 1)); // 0
    tbl.push_back(mk(0,1,0,0,0,0,0, 36'h0_0000_0000, 0, 1, 0, 1));
    tbl.push_back(mk(0,0,1,0,0,0,0, 36'h0_0000_1000, 0, 1, 0, 1));
    tbl.push_back(mk(0,0,1,0,0,0,0, 36'h0_0000_2000, 0, 1, 0, 1));
    tbl.push_back(mk(0,0,1,0,0,0,0, 36'h0_0000_3000, 0, 1, 0, 1));
    tbl.push_back(mk(0,1,0,0,0,0,0, 36'h0_0000_3000, 1, 0, 0, 1)); // 5 LOAD
    tbl.push_back(mk(0,0,0,0,0,0,0, 36'h0_0000_3000, 0, 0, 0, 1));
    tbl.push_back(mk(0,0,0,0,0,0,0, 36'h0_0000_3000, 0, 0, 0, 1));
    tbl.push_back(mk(0,1,0,0,0,0,0, 36'h0_0000_3000, 0, 1, 0, 1));
    tbl.push_back(mk(0,0,0,0,1,0,0, 36'h0_0000_3000, 0, 1, 1, 1));
    tbl.push_back(mk(0,0,1,0,0,0,0, 36'h0_0001_3000, 0, 1, 1, 1)); // 10
    tbl.push_back(mk(0,0,1,0,0,0,0, 36'h0_0002_3000, 0, 1, 1, 1));
    tbl.push_back(mk(0,0,1,0,0,0,0, 36'h0_0003_3000, 0, 1, 1, 1));
    tbl.push_back(mk(0,0,1,0,0,0,0, 36'h0_0004_3000, 0, 1, 1, 1));
    tbl.push_back(mk(0,0,1,0,0,0,0, 36'h0_0005_3000, 0, 1, 1, 1));
    tbl.push_back(mk(0,0,1,0,0,0,0, 36'h0_0000_3000, 0, 1, 1, 1)); // 15 s2 wrap
    tbl.push_back(mk(0,0,0,1,0,0,0, 36'h0_0005_3000, 0, 1, 1, 1));
    tbl.push_back(mk(1,0,0,0,0,0,0, 36'h0_0000_0000, 0, 0, 0, 1));
    tbl.push_back(mk(0,1,0,0,0,0,0, 36'h0_0000_0000, 0, 1, 0, 1));
    tbl.push_back(mk(0,0,0,0,0,1,0, 36'h0_0000_0000, 0, 1, 5, 1));
    tbl.push_back(mk(0,0,0,1,0,0,0, 36'h9_0000_0000, 0, 1, 5, 1)); // 20 h2 wrap
    tbl.push_back(mk(0,1,1,0,0,0,0, 36'h9_0000_0000, 1, 0, 5, 1)); // c+u
    tbl.push_back(mk(0,0,0,0,0,0,0, 36'h9_0000_0000, 0, 0, 5, 1));
    tbl.push_back(mk(0,1,0,0,0,0,0, 36'h9_0000_0000, 0, 1, 0, 1));
    tbl.push_back(mk(0,0,1,0,1,0,0, 36'h9_0000_1000, 0, 1, 0, 1)); // u+l
    tbl.push_back(mk(0,0,0,1,1,1,0, 36'h9_0000_0000, 0, 1, 0, 1)); // 25 d+l+r
    tbl.push_back(mk(0,0,0,0,1,1,0, 36'h9_0000_0000, 0, 1, 1, 1)); // l+r
    tbl.push_back(mk(0,0,0,0,0,0,1, 36'h9_0000_0000, 0, 0, 1, 1)); // abort
    tbl.push_back(mk(0,0,0,0,0,0,0, 36'h9_0000_0000, 0, 0, 1, 1));
    tbl.push_back(mk(0,1,0,0,0,0,1, 36'h9_0000_0000, 0, 0, 1, 1)); // c blocked
    tbl.push_back(mk(0,0,1,0,0,0,0, 36'h9_0000_0000, 0, 0, 1, 1)); // 30 u ignored
    tbl.push_back(mk(0,1,0,0,0,0,0, 36'h9_0000_0000, 0, 1, 0, 1));
    tbl.push_back(mk(0,1,0,0,0,0,1, 36'h9_0000_0000, 0, 0, 0, 1)); // abort beats c
    tbl.push_back(mk(0,0,0,0,0,0,0, 36'h9_0000_0000, 0, 0, 0, 1));
    tbl.push_back(mk(0,1,0,0,0,0,0, 36'h9_0000_0000, 0, 1, 0, 1));
    tbl.push_back(mk(0,0,0,0,0,1,0, 36'h9_0000_0000, 0, 1, 5, 1)); // 35 r wrap
    tbl.push_back(mk(0,0,0,0,1,0,0, 36'h9_0000_0000, 0, 1, 0, 1)); // l wrap
    tbl.push_back(mk(0,0,0,1,0,0,0, 36'h9_0000_9000, 0, 1, 0, 1)); // s1 wrap
    tbl.push_back(mk(0,0,1,0,0,0,0, 36'h9_0000_0000, 0, 1, 0, 1));

    #2;
    foreach (tbl[i]) begin
      if (tbl[i].rst) do_reset();
      else pulse(tbl[i].c, tbl[i].u, tbl[i].d, tbl[i].l, tbl[i].r, tbl[i].run);
      chk($sformatf("v%0d preset", i), preset_o,        tbl[i].preset);
      chk($sformatf("v%0d load",   i), 36'(load_o),     36'(tbl[i].ld));
      chk($sformatf("v%0d edit",   i), 36'(edit_o),     36'(tbl[i].ed));
      chk($sformatf("v%0d cursor", i), 36'(cursor_o),   36'(tbl[i].cur));
      chk($sformatf("v%0d blink",  i), 36'(blink_o),    36'(tbl[i].bl));
    end

    // Blink cadence: period 10 cycles, counted from entry into EDIT.
    do_reset();
    pulse(1, 0, 0, 0, 0, 0);
    for (int k = 1; k <= 30; k++) begin
      idle_cycle();
      chk($sformatf("blink k=%0d", k), 36'(blink_o), 36'((k >= 10 && k < 20) || k == 30 ? 0 : 1));
    end
    // An action while dark forces visible and restarts the 10-cycle phase.
    pulse(0, 1, 0, 0, 0, 0);
    chk("blink after u", 36'(blink_o), 36'(1));
    for (int k = 1; k <= 10; k++) begin
      idle_cycle();
      chk($sformatf("blink reload k=%0d", k), 36'(blink_o), 36'(k == 10 ? 0 : 1));
    end
    chk("preset after blink u", preset_o, 36'h0_0000_1000);
    pulse(0, 0, 0, 0, 0, 1);
    chk("blink idle after abort", 36'(blink_o), 36'(1));
    chk("edit after abort", 36'(edit_o), 36'(0));

    // Asynchronous reset landing on the LOAD cycle.
    do_reset();
    pulse(1, 0, 0, 0, 0, 0);
    pulse(0, 1, 0, 0, 0, 0);
    pulse(1, 0, 0, 0, 0, 0);
    chk("load before reset", 36'(load_o), 36'(1));
    chk("preset before reset", preset_o, 36'h0_0000_1000);
    #2 resetn = 1'b0;
    #1;
    chk("load during reset", 36'(load_o), 36'(0));
    chk("preset during reset", preset_o, 36'h0);
    chk("edit during reset", 36'(edit_o), 36'(0));
    @(posedge clk_i); #1;
    resetn = 1'b1;
    idle_cycle();
    chk("load after release", 36'(load_o), 36'(0));
    chk("edit after release", 36'(edit_o), 36'(0));
    pulse(0, 1, 0, 0, 0, 0);
    chk("u before fresh c", preset_o, 36'h0);
    chk("edit before fresh c", 36'(edit_o), 36'(0));
    pulse(1, 0, 0, 0, 0, 0);
    chk("edit after fresh c", 36'(edit_o), 36'(1));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
